ssr_cmd_seq: RTL and testbench

Command sequencer in front of the 64-bit shift/set/reset register (SSR) in the calculator datapath. It accepts one command at a time over a valid/ready handshake. Each command is expanded into a timed sequence of SSR control codes (S, ii, data_in), for example multi-bit shifts and high-bit masking. A one-cycle done pulse marks completion. The block has no storage of operand data beyond the latched command; the SSR itself holds the value.

---
 rtl/ssr_pkg.sv | 30 +++
 rtl/ssr_cmd_seq.sv | 146 ++++++++++++++
 tb/tb_ssr_cmd_seq.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssr_pkg.sv
// Shared definitions for the SSR command sequencer:
// opcodes, SSR control codes and FSM state encoding.
package ssr_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_IDX_W  = 6;

  localparam logic [2:0] SSR_HOLD = 3'b000;
  localparam logic [2:0] SSR_LOAD = 3'b001;
  localparam logic [2:0] SSR_SHL  = 3'b010;
  localparam logic [2:0] SSR_SHR  = 3'b011;
  localparam logic [2:0] SSR_CLR  = 3'b100;
  localparam logic [2:0] SSR_SET  = 3'b101;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_CLRB  = 3'b100;
  localparam logic [2:0] OP_SETB  = 3'b101;
  localparam logic [2:0] OP_CLRHI = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ssr_cmd_seq.sv
// Expands one accepted command into a timed run of
// SSR control codes, then pulses cmd_done.
module ssr_cmd_seq
  import ssr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_amt,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_done,
  output logic              cmd_err,
  output logic [2:0]        ssr_s,
  output logic [IDX_W-1:0]  ssr_ii,
  output logic [DATA_W-1:0] ssr_data_in
);

  localparam logic [IDX_W:0] ONE_N  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] FULL_N = (IDX_W+1)'(DATA_W);
  localparam logic [IDX_W-1:0] TOP_II = IDX_W'(DATA_W-1);

  state_t            state, state_n;
  logic [IDX_W:0]    cnt, cnt_n, num;
  logic [2:0]        op, op_n;
  logic [2:0]        code, s_n;
  logic [IDX_W-1:0]  first_ii, ii_n;
  logic [DATA_W-1:0] data_n;
  logic              done_n, err_n, ready_n;

  // issue count and first code of the offered command
  always_comb begin
    num      = '0;
    code     = SSR_HOLD;
    first_ii = ssr_ii;
    case (cmd_op)
      OP_LOAD: begin
        num  = ONE_N;
        code = SSR_LOAD;
      end
      OP_SHL: begin
        num  = {1'b0, cmd_amt};
        code = SSR_SHL;
      end
      OP_SHR: begin
        num  = {1'b0, cmd_amt};
        code = SSR_SHR;
      end
      OP_CLRB: begin
        num      = ONE_N;
        code     = SSR_CLR;
        first_ii = cmd_amt;
      end
      OP_SETB: begin
        num      = ONE_N;
        code     = SSR_SET;
        first_ii = cmd_amt;
      end
      OP_CLRHI: begin
        num      = FULL_N - {1'b0, cmd_amt};
        code     = SSR_CLR;
        first_ii = TOP_II;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op;
    s_n     = SSR_HOLD;
    ii_n    = ssr_ii;
    data_n  = ssr_data_in;
    done_n  = 1'b0;
    err_n   = 1'b0;
    ready_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          op_n    = cmd_op;
          ready_n = 1'b0;
          if (num == '0) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
            err_n   = (cmd_op == OP_ILL);
          end else begin
            state_n = ST_RUN;
            cnt_n   = num - ONE_N;
            s_n     = code;
            ii_n    = first_ii;
            if (cmd_op == OP_LOAD)
              data_n = cmd_data;
          end
        end
      end
      ST_RUN: begin
        // cnt counts issues still owed after this cycle
        if (cnt == '0) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - ONE_N;
          s_n   = ssr_s;
          if (op == OP_CLRHI)
            ii_n = ssr_ii - IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op          <= OP_NOP;
      ssr_s       <= SSR_HOLD;
      ssr_ii      <= '0;
      ssr_data_in <= '0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      op          <= op_n;
      ssr_s       <= s_n;
      ssr_ii      <= ii_n;
      ssr_data_in <= data_n;
      cmd_done    <= done_n;
      cmd_err     <= err_n;
      cmd_ready   <= ready_n;
    end
  end

endmodule

// File: tb/tb_ssr_cmd_seq.sv
// Bench for ssr_cmd_seq: an attached SSR plus a
// queue-based reference model of the issue timeline.
module tb_ssr_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [5:0]  cmd_amt;
  logic [63:0] cmd_data;
  logic        cmd_done;
  logic        cmd_err;
  logic [2:0]  ssr_s;
  logic [5:0]  ssr_ii;
  logic [63:0] ssr_data_in;

  ssr_cmd_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_amt     (cmd_amt),
    .cmd_data    (cmd_data),
    .cmd_done    (cmd_done),
    .cmd_err     (cmd_err),
    .ssr_s       (ssr_s),
    .ssr_ii      (ssr_ii),
    .ssr_data_in (ssr_data_in)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%h required=%h t=%0t",
                 name, act, exp, $time);
    end
  endtask

  // SSR attached beside the sequencer (no reset)
  logic [63:0] ssr;
  always @(posedge clk) begin
    case (ssr_s)
      3'd1: ssr <= ssr_data_in;
      3'd2: ssr <= ssr << 1;
      3'd3: ssr <= ssr >> 1;
      3'd4: ssr[ssr_ii] <= 1'b0;
      3'd5: ssr[ssr_ii] <= 1'b1;
      default: ;
    endcase
  end

  // Reference: every accepted command becomes a list of
  // per-cycle expected outputs, replayed one per cycle.
  typedef struct packed {
    logic        ready;
    logic        done;
    logic        err;
    logic [2:0]  s;
    logic [5:0]  ii;
    logic [63:0] data;
  } rec_t;

  localparam rec_t IDLE_R = '{ready: 1'b1, done: 1'b0,
    err: 1'b0, s: 3'd0, ii: 6'd0, data: 64'd0};

  rec_t q[$];
  rec_t cur = IDLE_R;

  task automatic push_cmd(input logic [2:0] op,
                          input logic [5:0] amt,
                          input logic [63:0] d);
    int n;
    logic [2:0] code;
    rec_t r;
    n = 0;
    code = 3'd0;
    case (op)
      3'd1: begin n = 1; code = 3'd1; end
      3'd2: begin n = int'(amt); code = 3'd2; end
      3'd3: begin n = int'(amt); code = 3'd3; end
      3'd4: begin n = 1; code = 3'd4; end
      3'd5: begin n = 1; code = 3'd5; end
      3'd6: begin n = 64 - int'(amt); code = 3'd4; end
      default: n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      r = IDLE_R;
      r.ready = 1'b0;
      r.s = code;
      r.ii = (op == 3'd6) ? 6'(63 - i) : amt;
      r.data = d;
      q.push_back(r);
    end
    r = IDLE_R;
    r.ready = 1'b0;
    r.done = 1'b1;
    r.err = (op == 3'd7);
    q.push_back(r);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      cur <= IDLE_R;
    end else begin
      if (cur.ready && cmd_valid)
        push_cmd(cmd_op, cmd_amt, cmd_data);
      if (q.size() > 0) cur <= q.pop_front();
      else cur <= IDLE_R;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {63'd0, cmd_ready}, {63'd0, cur.ready});
      check("ssr_s", {61'd0, ssr_s}, {61'd0, cur.s});
      check("done", {63'd0, cmd_done}, {63'd0, cur.done});
      if (cur.done)
        check("err", {63'd0, cmd_err}, {63'd0, cur.err});
      if (cur.s == 3'd4 || cur.s == 3'd5)
        check("ssr_ii", {58'd0, ssr_ii}, {58'd0, cur.ii});
      if (cur.s == 3'd1)
        check("data_in", ssr_data_in, cur.data);
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_cmd(input logic [2:0] op,
                        input logic [5:0] amt,
                        input logic [63:0] d,
                        output int lat,
                        output logic err);
    int t;
    int k;
    lat = -1;
    err = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_amt = amt;
    cmd_data = d;
    t = 0;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("hs_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    k = cyc;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom);
    cmd_amt = 6'($urandom);
    cmd_data = {$urandom, $urandom};
    t = 0;
    while (!cmd_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_done) begin
      check("done_timeout", 64'd0, 64'd1);
      return;
    end
    lat = cyc - k;
    err = cmd_err;
  endtask

  int   lat;
  logic err;
  int   k5;
  int   n_acc;
  int   acc[2];

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_amt = 6'd0;
    cmd_data = 64'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_s", {61'd0, ssr_s}, 64'd0);
    check("rst_ii", {58'd0, ssr_ii}, 64'd0);
    check("rst_data", ssr_data_in, 64'd0);
    check("rst_done", {63'd0, cmd_done}, 64'd0);
    check("rst_err", {63'd0, cmd_err}, 64'd0);
    check("rst_ready", {63'd0, cmd_ready}, 64'd1);
    rst_n = 1'b1;

    do_cmd(3'd1, 6'd0, 64'h0123_4567_89AB_CDEF, lat, err);
    check("load_lat", 64'(lat), 64'd1);
    check("load_err", {63'd0, err}, 64'd0);
    check("load_ssr", ssr, 64'h0123_4567_89AB_CDEF);

    do_cmd(3'd1, 6'd0, 64'h1, lat, err);
    do_cmd(3'd2, 6'd5, 64'd0, lat, err);
    check("shl5_lat", 64'(lat), 64'd5);
    check("shl5_ssr", ssr, 64'h20);
    do_cmd(3'd3, 6'd0, 64'd0, lat, err);
    check("shr0_lat", 64'(lat), 64'd0);
    check("shr0_ssr", ssr, 64'h20);

    do_cmd(3'd1, 6'd0, '1, lat, err);
    do_cmd(3'd6, 6'd60, 64'd0, lat, err);
    check("clrhi60_lat", 64'(lat), 64'd4);
    check("clrhi60_ssr", ssr, 64'h0FFF_FFFF_FFFF_FFFF);
    do_cmd(3'd6, 6'd0, 64'd0, lat, err);
    check("clrhi0_lat", 64'(lat), 64'd64);
    check("clrhi0_ssr", ssr, 64'd0);

    do_cmd(3'd5, 6'd63, 64'd0, lat, err);
    check("setb_ssr", ssr, 64'h8000_0000_0000_0000);
    do_cmd(3'd4, 6'd63, 64'd0, lat, err);
    check("clrb_ssr", ssr, 64'd0);
    do_cmd(3'd7, 6'd9, 64'd0, lat, err);
    check("ill_lat", 64'(lat), 64'd0);
    check("ill_err", {63'd0, err}, 64'd1);
    check("ill_ssr", ssr, 64'd0);

    // reset lands in the 10th RUN cycle of SHL 40
    do_cmd(3'd1, 6'd0, 64'h1, lat, err);
    wait_idle();
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    cmd_amt = 6'd40;
    @(negedge clk);
    k5 = cyc;
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("rst5_cycle", 64'(cyc - k5), 64'd9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst5_s", {61'd0, ssr_s}, 64'd0);
    check("rst5_done", {63'd0, cmd_done}, 64'd0);
    check("rst5_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst5_ssr", ssr, 64'h400);

    // valid held high, payload churning while busy
    wait_idle();
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_amt = 6'd0;
    cmd_data = 64'hA5;
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (cmd_ready && n_acc < 2) begin
        acc[n_acc] = cyc + 1;
        n_acc++;
      end
      @(negedge clk);
      if (n_acc >= 1) begin
        cmd_op = 3'($urandom_range(0, 7));
        cmd_amt = 6'($urandom_range(0, 7));
        cmd_data = {$urandom, $urandom};
      end
    end
    cmd_valid = 1'b0;
    check("hold_accepts", 64'(n_acc), 64'd2);
    if (n_acc == 2)
      check("hold_spacing", 64'(acc[1] - acc[0]), 64'd3);
    repeat (2) @(negedge clk);
    wait_idle();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op = 3'($urandom_range(0, 7));
      cmd_amt = 6'($urandom);
      cmd_data = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
